sd_spi_cmd_master: RTL and testbench

Synthesizable host-side SPI-mode SD command engine. It shifts out one 48-bit command frame, hunts for the response start bit on miso, and captures a response of programmable length. It reports a timeout if the card stays silent. It sits between the CPU/bootloader SD controller registers and the SD card pins, and it is verified against the behavioural sd card model.

---
 rtl/sd_spi_pkg.sv | 26 ++
 rtl/sd_spi_clkgen.sv | 58 +++++
 rtl/sd_spi_cmd_master.sv | 214 +++++++++++++++++++++
 tb/tb_sd_spi_cmd_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared types and constants for the SPI-mode SD command engine
// Purpose: FSM state encoding, SD response lengths and common command frames.
// Ports: none (package).
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    WAIT,
    RECV,
    DONE
  } sd_state_e;

  localparam int SD_CMD_BITS = 48;

  localparam int SD_R1_BITS = 8;
  localparam int SD_R3_BITS = 40;
  localparam int SD_R7_BITS = 40;

  localparam logic [47:0] SD_CMD0   = 48'h4000_0000_0095;
  localparam logic [47:0] SD_CMD8   = 48'h4800_0001_AA87;
  localparam logic [47:0] SD_CMD55  = 48'h7700_0000_00FF;
  localparam logic [47:0] SD_ACMD41 = 48'h6900_0000_00FF;

endpackage

// File: rtl/sd_spi_clkgen.sv
// rtl/sd_spi_clkgen.sv - mode-0 SPI clock generator with edge strobes
// Purpose: toggles sck every CLK_DIV clk cycles while enabled; when disabled,
//          sck is held low and the divider is cleared.
// Ports:
//   clk_i        system clock
//   resetn_i     asynchronous active-low reset
//   en_i         run the clock
//   sck_o        SPI clock, idles low
//   rise_stb_o   high in the clk cycle whose edge drives sck 0->1
//   fall_stb_o   high in the clk cycle whose edge drives sck 1->0
module sd_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  assign tick = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o      = sck_q;
  assign rise_stb_o = tick && !sck_q;
  assign fall_stb_o = tick && sck_q;

endmodule

// File: rtl/sd_spi_cmd_master.sv
// rtl/sd_spi_cmd_master.sv - host-side SPI-mode SD command/response engine
// Purpose: sends one 48-bit command frame MSB first, hunts for the response
//          start bit, captures resp_len bits right-aligned, or reports timeout.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (accept when both high)
//   cmd_data[47:0]              command frame including CRC byte
//   resp_len                    response bits to capture, clamped to [8, RESP_MAX_BITS]
//   resp_valid                  one-cycle completion pulse
//   resp_data, resp_timeout     result, held until the next resp_valid
//   busy                        FSM not in IDLE
//   sck, cs_n, mosi, miso       SPI pins (mode 0), miso synchronous to clk
module sd_spi_cmd_master
  import sd_spi_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int RESP_MAX_BITS = 48,
  parameter int TIMEOUT_BYTES = 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [47:0]                        cmd_data,
  input  logic [$clog2(RESP_MAX_BITS+1)-1:0] resp_len,
  output logic                               resp_valid,
  output logic [RESP_MAX_BITS-1:0]           resp_data,
  output logic                               resp_timeout,
  output logic                               busy,
  output logic                               sck,
  output logic                               cs_n,
  output logic                               mosi,
  input  logic                               miso
);

  localparam int LW        = $clog2(RESP_MAX_BITS + 1);
  localparam int CNT_MAX   = (RESP_MAX_BITS > SD_CMD_BITS) ? RESP_MAX_BITS : SD_CMD_BITS;
  localparam int BW        = $clog2(CNT_MAX + 1);
  localparam int WAIT_BITS = TIMEOUT_BYTES * 8;
  localparam int WW        = $clog2(WAIT_BITS + 1);
  localparam int SW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  sd_state_e                state_q, state_d;
  logic [SW-1:0]            setup_cnt_q, setup_cnt_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]            wait_cnt_q, wait_cnt_d;
  logic [LW-1:0]            len_q, len_d;
  logic [47:0]              sh_q, sh_d;
  logic [RESP_MAX_BITS-1:0] cap_q, cap_d;
  logic                     tmo_q, tmo_d;
  logic                     cs_n_q, cs_n_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [RESP_MAX_BITS-1:0] resp_data_q, resp_data_d;
  logic                     resp_timeout_q, resp_timeout_d;

  logic                     sck_en, rise_stb, fall_stb;
  logic [LW-1:0]            len_clamped;

  // SETUP keeps sck parked low; the clock runs until DONE sees its falling edge.
  assign sck_en = (state_q == CMD) || (state_q == WAIT) ||
                  (state_q == RECV) || (state_q == DONE);

  sd_spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk_i     (clk),
    .resetn_i  (resetn),
    .en_i      (sck_en),
    .sck_o     (sck),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb)
  );

  always_comb begin
    len_clamped = resp_len;
    if (resp_len < LW'(SD_R1_BITS)) begin
      len_clamped = LW'(SD_R1_BITS);
    end else if (resp_len > LW'(RESP_MAX_BITS)) begin
      len_clamped = LW'(RESP_MAX_BITS);
    end
  end

  always_comb begin
    state_d        = state_q;
    setup_cnt_d    = setup_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    len_d          = len_q;
    sh_d           = sh_q;
    cap_d          = cap_q;
    tmo_d          = tmo_q;
    cs_n_d         = cs_n_q;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;

    // mosi is the MSB of sh_q; shifting in ones leaves mosi high once the
    // frame is exhausted, so WAIT/RECV/DONE need no special mosi handling.
    if (fall_stb) begin
      sh_d = {sh_q[46:0], 1'b1};
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          sh_d        = cmd_data;
          len_d       = len_clamped;
          cap_d       = '0;
          bit_cnt_d   = '0;
          wait_cnt_d  = '0;
          setup_cnt_d = '0;
          tmo_d       = 1'b0;
          cs_n_d      = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt_q == SW'(CLK_DIV - 1)) begin
          state_d = CMD;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      CMD: begin
        if (rise_stb) begin
          if (bit_cnt_q == BW'(SD_CMD_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = WAIT;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      WAIT: begin
        if (rise_stb) begin
          if (!miso) begin
            // The start bit is the response MSB.
            cap_d     = {cap_q[RESP_MAX_BITS-2:0], 1'b0};
            bit_cnt_d = BW'(1);
            state_d   = RECV;
          end else if (wait_cnt_q == WW'(WAIT_BITS - 1)) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
            tmo_d      = 1'b1;
            state_d    = DONE;
          end else begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end
      end
      RECV: begin
        if (rise_stb) begin
          cap_d     = {cap_q[RESP_MAX_BITS-2:0], miso};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if ((bit_cnt_q + BW'(1)) == BW'(len_q)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Entered on a rising edge, so the next strobe is the falling edge
        // that parks sck low.
        if (fall_stb) begin
          cs_n_d         = 1'b1;
          resp_valid_d   = 1'b1;
          resp_data_d    = tmo_q ? '0 : cap_q;
          resp_timeout_d = tmo_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      setup_cnt_q    <= '0;
      bit_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      len_q          <= '0;
      sh_q           <= '1;
      cap_q          <= '0;
      tmo_q          <= 1'b0;
      cs_n_q         <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      setup_cnt_q    <= setup_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      len_q          <= len_d;
      sh_q           <= sh_d;
      cap_q          <= cap_d;
      tmo_q          <= tmo_d;
      cs_n_q         <= cs_n_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  // Ready is held off during the resp_valid cycle so that cs_n stays high
  // for at least one full idle cycle between commands.
  assign cmd_ready    = (state_q == IDLE) && !resp_valid_q;
  assign busy         = (state_q != IDLE);
  assign cs_n         = cs_n_q;
  assign mosi         = sh_q[47];
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_sd_spi_cmd_master.sv
// tb/tb_sd_spi_cmd_master.sv - directed self-checking bench for sd_spi_cmd_master
module tb_sd_spi_cmd_master;
  import sd_spi_pkg::*;

  logic        clk;
  logic        resetn;
  logic        cmd_valid    [2];
  logic        cmd_ready    [2];
  logic [47:0] cmd_data     [2];
  logic [5:0]  resp_len     [2];
  logic        resp_valid   [2];
  logic [47:0] resp_data    [2];
  logic        resp_timeout [2];
  logic        busy         [2];
  logic        sck          [2];
  logic        cs_n         [2];
  logic        mosi         [2];
  logic        miso         [2];

  // index 0: CLK_DIV=4, index 1: CLK_DIV=1
  sd_spi_cmd_master #(.CLK_DIV(4)) u_dut_div4 (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_data(cmd_data[0]), .resp_len(resp_len[0]), .resp_valid(resp_valid[0]),
    .resp_data(resp_data[0]), .resp_timeout(resp_timeout[0]), .busy(busy[0]),
    .sck(sck[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  sd_spi_cmd_master #(.CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_data(cmd_data[1]), .resp_len(resp_len[1]), .resp_valid(resp_valid[1]),
    .resp_data(resp_data[1]), .resp_timeout(resp_timeout[1]), .busy(busy[1]),
    .sck(sck[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // card model configuration
  int          ncr    [2];
  int          rlen   [2];
  logic [47:0] rsp    [2];
  logic        silent [2];
  logic        noise  [2];

  // monitor state
  int          rise_cnt      [2];
  int          rv_cnt        [2];
  int          rises_at_done [2];
  int          hi_run        [2];
  logic        prev_sck      [2];
  logic        prev_cs       [2];
  logic [47:0] frame, last_frame, prev_frame;
  int          mosi_bad;
  int          min_gap;

  function automatic logic stream_bit(input int i, input int idx);
    int p;
    if (silent[i]) return 1'b1;
    if (idx <= 48) return noise[i] ? 1'b0 : 1'b1;
    p = idx - 49 - ncr[i];
    if (p >= 0 && p < rlen[i]) return rsp[i][rlen[i]-1-p];
    return 1'b1;
  endfunction

  // Card model and pin monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (resp_valid[i]) begin
        rv_cnt[i]++;
        rises_at_done[i] = rise_cnt[i];
      end
      if (cs_n[i]) begin
        if (!prev_cs[i] && i == 0) begin
          prev_frame = last_frame;
          last_frame = frame;
        end
        rise_cnt[i] = 0;
        hi_run[i]++;
      end else begin
        if (prev_cs[i]) begin
          if (i == 0) begin
            if (hi_run[0] < min_gap) min_gap = hi_run[0];
            frame = '0;
          end
          hi_run[i] = 0;
        end
        if (sck[i] && !prev_sck[i]) begin
          rise_cnt[i]++;
          if (i == 0) begin
            if (rise_cnt[0] <= 48) frame = {frame[46:0], mosi[0]};
            else if (!mosi[0]) mosi_bad++;
          end
        end
      end
      prev_sck[i] = sck[i];
      prev_cs[i]  = cs_n[i];
      miso[i]     = cs_n[i] ? 1'b1 : stream_bit(i, rise_cnt[i] + 1);
    end
  end

  task automatic set_model(input int i, input int n_ncr, input int n_len,
                           input logic [47:0] r, input logic sil, input logic nz);
    ncr[i]    = n_ncr;
    rlen[i]   = n_len;
    rsp[i]    = r;
    silent[i] = sil;
    noise[i]  = nz;
  endtask

  // Returns clk edges from the accept edge to the edge that raises resp_valid.
  task automatic run_cmd(input int i, input logic [47:0] cmd, input logic [5:0] len,
                         output int cyc);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!cmd_ready[i] && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid[i] = 1'b1;
    cmd_data[i]  = cmd;
    resp_len[i]  = len;
    @(negedge clk);
    cmd_valid[i] = 1'b0;
    cyc = 0;
    while (!resp_valid[i] && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (!resp_valid[i]) cyc = -1;
    @(negedge clk);
  endtask

  int cyc, rv0, guard;

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_data[i]  = '0;
      resp_len[i]  = 6'd8;
      miso[i]      = 1'b1;
      rise_cnt[i]  = 0;
      rv_cnt[i]    = 0;
      hi_run[i]    = 0;
      prev_sck[i]  = 1'b0;
      prev_cs[i]   = 1'b1;
      rises_at_done[i] = 0;
      set_model(i, 8, 8, 48'h01, 1'b0, 1'b0);
    end
    frame = '0; last_frame = '0; prev_frame = '0;
    mosi_bad = 0;
    min_gap = 1000;

    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready[0], 1);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_cs_sck_mosi", {cs_n[0], sck[0], mosi[0]}, 3'b101);
    check_eq("rst_resp", {resp_valid[0], resp_timeout[0], resp_data[0]}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // CMD0, R1=0x01 after one Ncr byte
    rv0 = rv_cnt[0];
    run_cmd(0, SD_CMD0, 6'd8, cyc);
    check_eq("cmd0_frame", last_frame, SD_CMD0);
    check_eq("cmd0_data", resp_data[0], 48'h01);
    check_eq("cmd0_timeout", resp_timeout[0], 0);
    check_eq("cmd0_cycles_div4", cyc, 2*4*(48+8+8)+4);
    check_eq("cmd0_cs_high", cs_n[0], 1);
    repeat (20) @(negedge clk);
    check_eq("cmd0_one_valid", rv_cnt[0] - rv0, 1);

    run_cmd(1, SD_CMD0, 6'd8, cyc);
    check_eq("cmd0_cycles_div1", cyc, 2*1*(48+8+8)+1);
    check_eq("cmd0_data_div1", resp_data[1], 48'h01);

    // CMD8 R7; miso driven low throughout the command phase must be ignored
    set_model(0, 16, 40, 48'h01_0000_01AA, 1'b0, 1'b1);
    run_cmd(0, SD_CMD8, 6'd40, cyc);
    check_eq("cmd8_frame", last_frame, SD_CMD8);
    check_eq("cmd8_data", resp_data[0], 48'h01_0000_01AA);
    check_eq("cmd8_cycles", cyc, 2*4*(48+16+40)+4);

    // silent card -> timeout after 64 WAIT rising edges
    set_model(0, 0, 0, 48'h0, 1'b1, 1'b0);
    run_cmd(0, SD_CMD0, 6'd8, cyc);
    check_eq("tmo_flag", resp_timeout[0], 1);
    check_eq("tmo_data", resp_data[0], 0);
    check_eq("tmo_rises", rises_at_done[0], 48 + 64);
    check_eq("tmo_cycles_div4", cyc, 2*4*112+4);
    set_model(1, 0, 0, 48'h0, 1'b1, 1'b0);
    run_cmd(1, SD_CMD0, 6'd8, cyc);
    check_eq("tmo_cycles_div1", cyc, 2*1*112+1);
    check_eq("tmo_flag_div1", resp_timeout[1], 1);

    // resp_len below 8 is captured as 8; start bit on the very first WAIT sample
    set_model(0, 0, 8, 48'h05, 1'b0, 1'b0);
    run_cmd(0, SD_CMD55, 6'd3, cyc);
    check_eq("len3_data", resp_data[0], 48'h05);
    check_eq("len3_timeout", resp_timeout[0], 0);
    check_eq("len3_cycles", cyc, 2*4*(48+0+8)+4);
    repeat (30) @(negedge clk);
    check_eq("len3_hold", resp_data[0], 48'h05);

    // resp_len above RESP_MAX_BITS is captured as 48
    set_model(0, 8, 48, 48'h3F12_3456_789A, 1'b0, 1'b0);
    run_cmd(0, SD_CMD0, 6'd63, cyc);
    check_eq("len63_data", resp_data[0], 48'h3F12_3456_789A);
    check_eq("len63_cycles", cyc, 2*4*(48+8+48)+4);

    // CMD55 then ACMD41 with cmd_valid held; a mid-CMD pulse with junk data
    set_model(0, 8, 8, 48'h01, 1'b0, 1'b0);
    mosi_bad = 0;
    @(negedge clk);
    min_gap = 1000;
    rv0 = rv_cnt[0];
    cmd_valid[0] = 1'b1;
    cmd_data[0]  = SD_CMD55;
    resp_len[0]  = 6'd8;
    guard = 0;
    while (!busy[0] && guard < 100) begin @(negedge clk); guard++; end
    cmd_data[0] = 48'hDEAD_BEEF_0001;
    guard = 0;
    while (rise_cnt[0] < 24 && guard < 1000) begin @(negedge clk); guard++; end
    check_eq("b2b_reach_mid", rise_cnt[0], 24);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    cmd_data[0]  = SD_ACMD41;
    cmd_valid[0] = 1'b1;
    guard = 0;
    while (!(rv_cnt[0] == rv0 + 1 && busy[0]) && guard < 3000) begin @(negedge clk); guard++; end
    check_eq("b2b_second_accepted", busy[0] && (rv_cnt[0] == rv0 + 1), 1);
    cmd_valid[0] = 1'b0;
    guard = 0;
    while (rv_cnt[0] != rv0 + 2 && guard < 3000) begin @(negedge clk); guard++; end
    @(negedge clk);
    check_eq("b2b_frame1", prev_frame, SD_CMD55);
    check_eq("b2b_frame2", last_frame, SD_ACMD41);
    check_eq("b2b_gap_ge1", min_gap >= 1, 1);
    repeat (1200) @(negedge clk);
    check_eq("b2b_two_valids", rv_cnt[0] - rv0, 2);
    check_eq("b2b_busy_after", busy[0], 0);
    check_eq("mosi_high_after_cmd", mosi_bad, 0);

    // asynchronous reset during command bit 20
    cmd_valid[0] = 1'b1;
    cmd_data[0]  = SD_CMD0;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    guard = 0;
    while (rise_cnt[0] < 20 && guard < 1000) begin @(negedge clk); guard++; end
    check_eq("rst_mid_reach", rise_cnt[0], 20);
    rv0 = rv_cnt[0];
    resetn = 1'b0;
    #1;
    check_eq("rst_mid_pins", {cs_n[0], sck[0], mosi[0]}, 3'b101);
    check_eq("rst_mid_ready", {cmd_ready[0], busy[0]}, 2'b10);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("rst_mid_no_valid", rv_cnt[0] - rv0, 0);
    run_cmd(0, SD_CMD0, 6'd8, cyc);
    check_eq("post_rst_frame", last_frame, SD_CMD0);
    check_eq("post_rst_data", resp_data[0], 48'h01);
    check_eq("post_rst_cycles", cyc, 2*4*(48+8+8)+4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
